// File: rtl/sync_trigger_fsm.sv
// Multi-channel synchronization trigger FSM: armed start, fast-gate shot counting, delayed trigger pulses.
// Optional input debounce filter enabled by defining SYNC_TRIG_DEBOUNCE_EN.
module sync_trigger_fsm #(
   parameter int CHANNELS        = 4,
   parameter int DELAY_CYCLES    = 400_000,
   parameter int PULSE_CYCLES    = 20_000,
   parameter int SHOT_W          = 8,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start_signal,
   input  logic                fg_signal,
   input  logic [CHANNELS-1:0] channel_enable,
   input  logic [CHANNELS-1:0] detector_ready,
   input  logic [SHOT_W-1:0]   shot_count,
   output logic [CHANNELS-1:0] detector_trigger,
   output logic                busy,
   output logic [SHOT_W-1:0]   shots_done,
   output logic                missed,
   output logic                done,
   output logic [1:0]          fsm_state_o
);

   localparam int MAX_CYC = (DELAY_CYCLES > PULSE_CYCLES) ? DELAY_CYCLES : PULSE_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0]  DELAY_LAST = CNT_W'(DELAY_CYCLES - 1);
   localparam logic [CNT_W-1:0]  PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [SHOT_W-1:0] SHOT_MAX   = '1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARMED = 2'd1;
   localparam logic [1:0] ST_DELAY = 2'd2;
   localparam logic [1:0] ST_FIRE  = 2'd3;

   // Bit 0 carries start, bit 1 carries fast gate through the whole input path.
   logic [1:0] sync1_q, sync2_q;
   logic [1:0] clean;
   logic [1:0] clean_prev_q;
   logic [1:0] edges;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q <= 2'b00;
         sync2_q <= 2'b00;
      end else begin
         sync1_q <= {fg_signal, start_signal};
         sync2_q <= sync1_q;
      end
   end

`ifdef SYNC_TRIG_DEBOUNCE_EN
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic [DB_W-1:0] db_cnt_q [2];
   logic [1:0]      filt_q;

   // The filtered level follows the raw level only after DEBOUNCE_CYCLES stable cycles.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         filt_q      <= 2'b00;
         db_cnt_q[0] <= '0;
         db_cnt_q[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == filt_q[i]) begin
               db_cnt_q[i] <= '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
               filt_q[i]   <= sync2_q[i];
               db_cnt_q[i] <= '0;
            end else begin
               db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
            end
         end
      end
   end

   assign clean = filt_q;
`else
   assign clean = sync2_q;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) clean_prev_q <= 2'b00;
      else       clean_prev_q <= clean;
   end

   assign edges = clean & ~clean_prev_q;

   logic                start_edge, fg_edge, all_ready;
   logic [1:0]          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CHANNELS-1:0] mask_q, mask_d;
   logic [CHANNELS-1:0] trig_q, trig_d;
   logic [SHOT_W-1:0]   count_q, count_d;
   logic [SHOT_W-1:0]   shots_q, shots_d;
   logic                missed_q, missed_d;
   logic                done_q, done_d;

   assign start_edge = edges[0];
   assign fg_edge    = edges[1];
   // Disabled channels count as ready, so an all-zero mask never blocks a shot.
   assign all_ready  = &(detector_ready | ~mask_q);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mask_d   = mask_q;
      trig_d   = trig_q;
      count_d  = count_q;
      shots_d  = shots_q;
      missed_d = 1'b0;
      done_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_edge) begin
               state_d = ST_ARMED;
               mask_d  = channel_enable;
               count_d = (shot_count == '0) ? SHOT_W'(1) : shot_count;
               shots_d = '0;
            end
         end
         ST_ARMED: begin
            if (fg_edge) begin
               if (all_ready) begin
                  state_d = ST_DELAY;
                  cnt_d   = '0;
               end else begin
                  missed_d = 1'b1;
               end
            end
         end
         ST_DELAY: begin
            if (cnt_q == DELAY_LAST) begin
               state_d = ST_FIRE;
               cnt_d   = '0;
               trig_d  = mask_q;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_FIRE: begin
            if (cnt_q == PULSE_LAST) begin
               trig_d  = '0;
               cnt_d   = '0;
               shots_d = (shots_q == SHOT_MAX) ? shots_q : shots_q + SHOT_W'(1);
               if ({1'b0, shots_q} + (SHOT_W+1)'(1) == {1'b0, count_q}) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_ARMED;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         mask_q   <= '0;
         trig_q   <= '0;
         count_q  <= '0;
         shots_q  <= '0;
         missed_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mask_q   <= mask_d;
         trig_q   <= trig_d;
         count_q  <= count_d;
         shots_q  <= shots_d;
         missed_q <= missed_d;
         done_q   <= done_d;
      end
   end

   assign detector_trigger = trig_q;
   assign busy             = (state_q != ST_IDLE);
   assign shots_done       = shots_q;
   assign missed           = missed_q;
   assign done             = done_q;
   assign fsm_state_o      = state_q;

endmodule

// File: tb/tb_sync_trigger_fsm.sv
// Directed bench for sync_trigger_fsm with CHANNELS=2, DELAY_CYCLES=8, PULSE_CYCLES=4.
// Debounce scenarios run only when SYNC_TRIG_DEBOUNCE_EN is defined.
module tb_sync_trigger_fsm;

   localparam int D = 8;
   localparam int P = 4;
`ifdef SYNC_TRIG_DEBOUNCE_EN
   localparam int LAT = 3 + 16;
`else
   localparam int LAT = 3;
`endif

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ARMED = 2'd1;
   localparam logic [1:0] S_DELAY = 2'd2;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_signal, fg_signal;
   logic [1:0] channel_enable, detector_ready;
   logic [7:0] shot_count;
   logic [1:0] detector_trigger;
   logic       busy, missed, done;
   logic [7:0] shots_done;
   logic [1:0] fsm_state;

   int total_cnt = 0;
   int pass_cnt  = 0;
   int fail_cnt  = 0;

   sync_trigger_fsm #(
      .CHANNELS(2), .DELAY_CYCLES(D), .PULSE_CYCLES(P), .SHOT_W(8), .DEBOUNCE_CYCLES(16)
   ) dut (
      .clock(clk), .reset(rst), .start_signal(start_signal), .fg_signal(fg_signal),
      .channel_enable(channel_enable), .detector_ready(detector_ready), .shot_count(shot_count),
      .detector_trigger(detector_trigger), .busy(busy), .shots_done(shots_done),
      .missed(missed), .done(done), .fsm_state_o(fsm_state)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input string tag);
      start_signal = 1'b1;
      step(LAT - 1);
      check({tag, "_busy_pre"}, 32'(busy), 32'd0);
      step(1);
      check({tag, "_busy_on"}, 32'(busy), 32'd1);
      check({tag, "_shots_clr"}, 32'(shots_done), 32'd0);
      start_signal = 1'b0;
      step(LAT + 1);
   endtask

   task automatic fire_shot(input string tag, input logic [1:0] m, input logic last, input int exp_shots);
      fg_signal = 1'b1;
      step(LAT + D - 1);
      check({tag, "_trig_pre"}, 32'(detector_trigger), 32'd0);
      step(1);
      check({tag, "_trig_on"}, 32'(detector_trigger), 32'(m));
      check({tag, "_shots_mid"}, 32'(shots_done), 32'(exp_shots - 1));
      step(P - 1);
      check({tag, "_trig_end"}, 32'(detector_trigger), 32'(m));
      step(1);
      check({tag, "_trig_off"}, 32'(detector_trigger), 32'd0);
      check({tag, "_shots"}, 32'(shots_done), 32'(exp_shots));
      check({tag, "_done"}, 32'(done), 32'(last));
      check({tag, "_busy"}, 32'(busy), 32'(!last));
      step(1);
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      fg_signal = 1'b0;
      step(LAT + 1);
   endtask

   initial begin
      rst            = 1'b1;
      start_signal   = 1'b0;
      fg_signal      = 1'b0;
      channel_enable = 2'b11;
      detector_ready = 2'b11;
      shot_count     = 8'd2;
      #1;
      check("rst_trig", 32'(detector_trigger), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_shots", 32'(shots_done), 32'd0);
      check("rst_missed", 32'(missed), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_state", 32'(fsm_state), 32'(S_IDLE));
      step(2);
      rst = 1'b0;
      step(2);

`ifdef SYNC_TRIG_DEBOUNCE_EN
      // A short fg glitch must be filtered; a long pulse fires at LAT + D.
      shot_count = 8'd1;
      do_start("db_start");
      fg_signal = 1'b1;
      step(5);
      fg_signal = 1'b0;
      step(LAT + D + P + 4);
      check("db_glitch_trig", 32'(detector_trigger), 32'd0);
      check("db_glitch_state", 32'(fsm_state), 32'(S_ARMED));
      check("db_glitch_shots", 32'(shots_done), 32'd0);
      fire_shot("db_long", 2'b11, 1'b1, 1);
      shot_count = 8'd2;
`endif

      // Basic two-shot run, fg edges 100 cycles apart.
      do_start("basic_start");
      fire_shot("basic_s1", 2'b11, 1'b0, 1);
      check("basic_state_armed", 32'(fsm_state), 32'(S_ARMED));
      step(80);
      fire_shot("basic_s2", 2'b11, 1'b1, 2);
      check("basic_state_idle", 32'(fsm_state), 32'(S_IDLE));

      // Enabled channel not ready: missed pulse, no trigger, then recovery.
      detector_ready = 2'b01;
      do_start("nr_start");
      fg_signal = 1'b1;
      step(LAT - 1);
      check("nr_missed_pre", 32'(missed), 32'd0);
      step(1);
      check("nr_missed_on", 32'(missed), 32'd1);
      step(1);
      check("nr_missed_off", 32'(missed), 32'd0);
      step(D + P);
      check("nr_no_trig", 32'(detector_trigger), 32'd0);
      check("nr_state", 32'(fsm_state), 32'(S_ARMED));
      fg_signal = 1'b0;
      step(LAT + 1);
      detector_ready = 2'b11;
      fire_shot("nr_s1", 2'b11, 1'b0, 1);
      fire_shot("nr_s2", 2'b11, 1'b1, 2);

      // Masked channel: not-ready channel 1 is disabled.
      channel_enable = 2'b01;
      detector_ready = 2'b01;
      do_start("mask_start");
      fire_shot("mask_s1", 2'b01, 1'b0, 1);
      fire_shot("mask_s2", 2'b01, 1'b1, 2);

      // Second start in ARMED and second fg edge in DELAY are ignored.
      channel_enable = 2'b11;
      detector_ready = 2'b11;
      do_start("ign_start");
      start_signal = 1'b1;
      step(LAT + 2);
      check("ign_start_state", 32'(fsm_state), 32'(S_ARMED));
      check("ign_start_shots", 32'(shots_done), 32'd0);
      start_signal = 1'b0;
      step(LAT + 1);
      fg_signal = 1'b1;
      step(LAT + 2);
      check("ign_in_delay", 32'(fsm_state), 32'(S_DELAY));
      fg_signal = 1'b0;
      step(2);
      fg_signal = 1'b1;
      step(D - 5);
      check("ign_trig_pre", 32'(detector_trigger), 32'd0);
      check("ign_missed", 32'(missed), 32'd0);
      step(1);
      check("ign_trig_on", 32'(detector_trigger), 32'd3);
      step(P);
      check("ign_trig_off", 32'(detector_trigger), 32'd0);
      check("ign_shots", 32'(shots_done), 32'd1);
      step(D + P + 3);
      check("ign_no_extra", 32'(detector_trigger), 32'd0);
      check("ign_shots_hold", 32'(shots_done), 32'd1);
      check("ign_state", 32'(fsm_state), 32'(S_ARMED));
      fg_signal = 1'b0;
      step(LAT + 1);

      // Asynchronous reset while the trigger is high.
      fg_signal = 1'b1;
      step(LAT + D + 1);
      check("rf_trig_high", 32'(detector_trigger), 32'd3);
      #2;
      rst = 1'b1;
      #1;
      check("rf_trig", 32'(detector_trigger), 32'd0);
      check("rf_state", 32'(fsm_state), 32'(S_IDLE));
      check("rf_shots", 32'(shots_done), 32'd0);
      check("rf_busy", 32'(busy), 32'd0);
      fg_signal = 1'b0;
      #3;
      rst = 1'b0;
      step(LAT + 2);

      // A shot count of zero behaves as one shot.
      shot_count = 8'd0;
      do_start("zero_start");
      fire_shot("zero_s1", 2'b11, 1'b1, 1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
